// File: rtl/fp4_pkg.sv
// fp4_pkg: FP4 (E2M1) operand type and special encodings shared by the MAC datapath.
package fp4_pkg;

    typedef struct packed {
        logic       s;
        logic [1:0] e;
        logic       m;
    } fp4_t;

    localparam fp4_t FP4_ZERO = 4'b0000;
    localparam fp4_t FP4_INF  = 4'b0110;
    localparam fp4_t FP4_NAN  = 4'b1111;

endpackage

// File: rtl/fp4_rsp_fifo.sv
// fp4_rsp_fifo: first-word-fall-through FIFO of {fp4_t result, requester id}.
module fp4_rsp_fifo
    import fp4_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDW   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  fp4_t                       push_z,
    input  logic [IDW-1:0]             push_id,
    output fp4_t                       pop_z,
    output logic [IDW-1:0]             pop_id,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fp4_t           z_q  [DEPTH];
    fp4_t           z_d  [DEPTH];
    logic [IDW-1:0] id_q [DEPTH];
    logic [IDW-1:0] id_d [DEPTH];
    logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop = pop && cnt_q != '0;
        z_d    = z_q;
        id_d   = id_q;
        if (push) begin
            z_d[wr_q]  = push_z;
            id_d[wr_q] = push_id;
        end
        wr_d  = push ? nxt(wr_q) : wr_q;
        rd_d  = do_pop ? nxt(rd_q) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q   <= '{default: '0};
            id_q  <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            z_q   <= z_d;
            id_q  <= id_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Masked when empty so the outputs read zero rather than a stale entry.
    assign empty  = cnt_q == '0;
    assign count  = cnt_q;
    assign pop_z  = empty ? '0 : z_q[rd_q];
    assign pop_id = empty ? '0 : id_q[rd_q];

endmodule

// File: rtl/fp4_mul_arbiter.sv
// fp4_mul_arbiter: round-robin sharing of one pipelined FP4 multiplier between NREQ requesters,
// with a latency-matched id tag pipe and a credit-protected in-order response FIFO.
module fp4_mul_arbiter
    import fp4_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MUL_LAT   = 3,
    parameter int RSP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][3:0]       req_a,
    input  logic [NREQ-1:0][3:0]       req_b,
    output logic                       mul_issue,
    output logic [3:0]                 mul_a,
    output logic [3:0]                 mul_b,
    input  logic [3:0]                 mul_z,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [3:0]                 rsp_z,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic                       busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CRW = $clog2(RSP_DEPTH + 1);

    logic [IDW-1:0]     last_q, last_d, gid, idx;
    logic [CRW-1:0]     credits_q, credits_d, rsp_cnt;
    logic [MUL_LAT-1:0] vld_q, vld_d;
    logic [IDW-1:0]     tid_q [MUL_LAT];
    logic [IDW-1:0]     tid_d [MUL_LAT];
    logic               found, accept, pop, empty;

    always_comb begin
        found = 1'b0;
        gid   = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gid   = idx;
            end
        end
        // A credit reserves a FIFO slot for the whole trip through the multiplier.
        accept    = found && credits_q != '0 && !rst;
        pop       = rsp_valid && rsp_ready;
        req_ready = accept ? NREQ'(1) << gid : '0;
        mul_issue = accept;
        mul_a     = accept ? req_a[gid] : '0;
        mul_b     = accept ? req_b[gid] : '0;
        last_d    = accept ? gid : last_q;
        credits_d = credits_q - CRW'(accept) + CRW'(pop);
        vld_d     = '0;
        tid_d     = tid_q;
        vld_d[0]  = accept;
        tid_d[0]  = gid;
        for (int i = 1; i < MUL_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tid_d[i] = tid_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q    <= IDW'(NREQ - 1);
            credits_q <= CRW'(RSP_DEPTH);
            vld_q     <= '0;
            tid_q     <= '{default: '0};
        end else begin
            last_q    <= last_d;
            credits_q <= credits_d;
            vld_q     <= vld_d;
            tid_q     <= tid_d;
        end
    end

    fp4_rsp_fifo #(.DEPTH(RSP_DEPTH), .IDW(IDW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (vld_q[MUL_LAT-1]),
        .pop     (pop),
        .push_z  (mul_z),
        .push_id (tid_q[MUL_LAT-1]),
        .pop_z   (rsp_z),
        .pop_id  (rsp_id),
        .empty   (empty),
        .count   (rsp_cnt)
    );

    assign rsp_valid = !empty;
    assign busy      = |vld_q || rsp_cnt != '0;

endmodule

// File: tb/tb_fp4_mul_arbiter.sv
// tb_fp4_mul_arbiter: directed checks of arbitration order, latency, credits and reset flush,
// using an XOR stub in place of the multiplier.
module tb_fp4_mul_arbiter;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req_valid = '0;
    logic [3:0]      req_ready;
    logic [3:0][3:0] req_a = '0;
    logic [3:0][3:0] req_b = '0;
    logic            mul_issue;
    logic [3:0]      mul_a, mul_b, mul_z;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [3:0]      rsp_z;
    logic [1:0]      rsp_id;
    logic            busy;
    logic [2:0][3:0] pipe = '0;
    int              n_tests = 0;
    int              n_fail = 0;
    int              max_cnt = 0;
    int              expq[$];

    fp4_mul_arbiter #(.NREQ(4), .MUL_LAT(3), .RSP_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_issue (mul_issue),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_z     (mul_z),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pipe <= {pipe[1:0], mul_issue ? mul_a ^ mul_b : 4'h0};
    assign mul_z = pipe[2];

    always @(negedge clk) if (int'(dut.rsp_cnt) > max_cnt) max_cnt = int'(dut.rsp_cnt);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int nxt(input int g, input logic [3:0] m);
        for (int k = 1; k <= 4; k++)
            if (m[(g + k) % 4]) return (g + k) % 4;
        return g;
    endfunction

    task automatic rsp_check;
        int id;
        if (rsp_valid && rsp_ready) begin
            if (expq.size() == 0) begin
                check("rsp_spurious", 1, 0);
            end else begin
                id = expq.pop_front();
                check("rsp_id", rsp_id, id);
                check("rsp_z", rsp_z, req_a[id] ^ req_b[id]);
            end
        end
    endtask

    task automatic run_rr(input int cycles, input logic [3:0] mask, inout int g, output int nacc);
        nacc = 0;
        for (int c = 0; c < cycles; c++) begin
            #1;
            check("rr_masked", req_ready & ~mask, 0);
            if (req_ready != 0) begin
                g = nxt(g, mask);
                check("rr_grant", req_ready, 4'h1 << g);
                check("rr_mul_a", mul_a, req_a[g]);
                expq.push_back(g);
                nacc++;
            end
            rsp_check();
            step();
        end
    endtask

    task automatic drain(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            #1;
            rsp_check();
            step();
        end
        check("drain_empty", expq.size(), 0);
    endtask

    initial begin
        int g;
        int n;
        logic [5:0] pat;
        step();
        step();
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_mul_issue", mul_issue, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_z", rsp_z, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_busy", busy, 0);
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        step();

        req_a[0] = 4'h2;
        req_b[0] = 4'h3;
        req_valid = 4'b0001;
        #1;
        check("t1_ready", req_ready, 4'b0001);
        check("t1_issue", mul_issue, 1);
        check("t1_mul_a", mul_a, 4'h2);
        check("t1_mul_b", mul_b, 4'h3);
        step();
        req_valid = '0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("t1_busy", busy, 1);
            check("t1_rsp_valid", rsp_valid, i == 4);
            if (i == 4) begin
                check("t1_rsp_z", rsp_z, 4'h1);
                check("t1_rsp_id", rsp_id, 0);
            end
            step();
        end
        #1;
        check("t1_idle_valid", rsp_valid, 0);
        check("t1_idle_busy", busy, 0);
        step();

        g = 0;
        for (int i = 0; i < 4; i++) begin
            req_a[i] = 4'(i);
            req_b[i] = 4'h8;
        end
        req_valid = 4'hF;
        run_rr(20, 4'hF, g, n);
        check("t2_accepts", n, 16);
        req_valid = '0;
        drain(10);

        req_a[1] = 4'h5;
        req_a[3] = 4'h7;
        req_valid = 4'b1010;
        run_rr(10, 4'b1010, g, n);
        check("t3_accepts", n, 8);
        check("t3_last", g, 3);
        req_valid = '0;
        drain(10);

        rsp_ready = 1'b0;
        req_valid = 4'hF;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready != 0) n++;
            step();
        end
        check("t4_accepts", n, 4);
        rsp_ready = 1'b1;
        #1;
        check("t4_no_credit_yet", req_ready, 0);
        check("t4_fifo_full", dut.rsp_cnt, 4);
        check("t4_rsp_valid", rsp_valid, 1);
        check("t4_rsp_id", rsp_id, 0);
        step();
        rsp_ready = 1'b0;
        #1;
        check("t4_one_accept", req_ready, 4'b0001);
        step();
        #1;
        check("t4_stall_again", req_ready, 0);
        for (int c = 0; c < 6; c++) step();
        #1;
        check("t4_refilled", dut.rsp_cnt, 4);
        step();

        rsp_ready = 1'b1;
        #1;
        check("t5_credits0", dut.credits_q, 0);
        check("t5_ready0", req_ready, 0);
        step();
        #1;
        check("t5_credits1", dut.credits_q, 1);
        check("t5_grant1", req_ready, 4'b0010);
        check("t5_pop", rsp_valid, 1);
        step();
        rsp_ready = 1'b0;
        #1;
        check("t5_credits_held", dut.credits_q, 1);
        check("t5_grant2", req_ready, 4'b0100);
        step();
        req_valid = '0;
        #1;
        check("t5_credits_out", dut.credits_q, 0);

        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) step();
        #1;
        check("t6_idle", busy, 0);
        step();
        rsp_ready = 1'b0;
        pat = 6'b110011;
        for (int c = 0; c < 6; c++) begin
            req_valid = pat[c] ? 4'hF : 4'h0;
            step();
        end
        req_valid = '0;
        #1;
        check("t6_pre_valid", rsp_valid, 1);
        check("t6_pre_cnt", dut.rsp_cnt, 2);
        check("t6_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", rsp_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_z", rsp_z, 0);
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("t6_credits", dut.credits_q, 4);
        for (int c = 0; c < 8; c++) begin
            step();
            #1;
            check("t6_no_stale", rsp_valid, 0);
            check("t6_busy", busy, 0);
        end
        step();
        req_valid = 4'hF;
        #1;
        check("t6_first_grant", req_ready, 4'b0001);
        check("t6_first_mul_a", mul_a, req_a[0]);
        step();
        req_valid = '0;

        check("fifo_max", max_cnt, 4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
